// File: rtl/cpu_mem_arbiter_if.sv
// Signal bundle between the CPU core's fetch and load/store ports, the
// memory arbiter, and the external memory/IO bus.
interface cpu_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Instruction-fetch port
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_done;

    // Load/store port
    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic [DATA_WIDTH-1:0] ls_rdata;
    logic                  ls_done;

    // External memory bus
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    // Watchdog abort flag, qualifies whichever done pulse is high
    logic                  err;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
               mem_rdata, mem_ready,
        output if_rdata, if_done, ls_rdata, ls_done,
               mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

    // Requester and memory view
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
               mem_rdata, mem_ready,
        input  if_rdata, if_done, ls_rdata, ls_done,
               mem_addr, mem_wdata, mem_rd, mem_wr, err
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares one external memory bus between the instruction-fetch (IF) and
// load/store (LS) ports. Each transfer is a one-cycle BEGIN strobe followed
// by a WAIT for mem_ready. Simultaneous requests alternate round-robin, and
// an optional wait-cycle watchdog aborts hung transfers with err=1.
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic             clk,
    input logic             reset,
    cpu_mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IF_BEGIN = 3'd1,
        IF_WAIT  = 3'd2,
        LS_BEGIN = 3'd3,
        LS_WAIT  = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_LS = 1'b1
    } grant_t;

    localparam bit         WATCHDOG_EN = (TIMEOUT != 0);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t                state;
    state_t                state_next;
    grant_t                last_grant;
    logic [7:0]            wait_cnt;
    logic                  ls_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] ls_rdata_q;
    logic                  if_done_q;
    logic                  ls_done_q;
    logic                  err_q;
    logic                  mem_rd_d;
    logic                  mem_wr_d;

    // A port whose done is high this cycle is not eligible, so a req held
    // across the done pulse cannot restart the same transfer.
    logic if_elig;
    logic ls_elig;
    logic in_wait;
    logic timed_out;

    assign if_elig   = bus.if_req & ~if_done_q;
    assign ls_elig   = bus.ls_req & ~ls_done_q;
    assign in_wait   = (state == IF_WAIT) || (state == LS_WAIT);
    // mem_ready on the same edge wins over the watchdog.
    assign timed_out = WATCHDOG_EN && !bus.mem_ready && (wait_cnt == TIMEOUT_CNT);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: arbitrate in IDLE, step BEGIN->WAIT, leave WAIT on ready or watchdog
    always_comb begin
        // NOTE: defaulting first means no path leaves state_next unassigned,
        // so no latch is inferred.
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (if_elig && ls_elig)
                    state_next = (last_grant == GRANT_IF) ? LS_BEGIN : IF_BEGIN;
                else if (if_elig)
                    state_next = IF_BEGIN;
                else if (ls_elig)
                    state_next = LS_BEGIN;
                else
                    state_next = IDLE;
            end
            IF_BEGIN: state_next = IF_WAIT;
            IF_WAIT:  state_next = (bus.mem_ready || timed_out) ? IDLE : IF_WAIT;
            LS_BEGIN: state_next = LS_WAIT;
            LS_WAIT:  state_next = (bus.mem_ready || timed_out) ? IDLE : LS_WAIT;
            default:  state_next = IDLE;
        endcase
    end

    // Bus strobes, decoded from the state register for the single BEGIN cycle
    always_comb begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        case (state)
            IF_BEGIN: mem_rd_d = 1'b1;
            LS_BEGIN: begin
                mem_rd_d = ~ls_we_q;
                mem_wr_d = ls_we_q;
            end
            default: ;
        endcase
    end

    // Datapath: latch the request on grant, count wait cycles, deliver done/rdata/err
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: data registers are cleared too, so the bus and the
            // rdata outputs read as zero after reset rather than as stale data.
            last_grant  <= GRANT_IF;
            wait_cnt    <= '0;
            ls_we_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            err_q     <= 1'b0;

            if (in_wait) wait_cnt <= wait_cnt + 8'd1;

            if (state == IDLE && state_next == IF_BEGIN) begin
                mem_addr_q <= bus.if_addr;
                last_grant <= GRANT_IF;
                wait_cnt   <= '0;
            end

            if (state == IDLE && state_next == LS_BEGIN) begin
                mem_addr_q  <= bus.ls_addr;
                mem_wdata_q <= bus.ls_wdata;
                ls_we_q     <= bus.ls_we;
                last_grant  <= GRANT_LS;
                wait_cnt    <= '0;
            end

            if (state == IF_WAIT) begin
                if (bus.mem_ready) begin
                    if_done_q  <= 1'b1;
                    if_rdata_q <= bus.mem_rdata;
                end else if (timed_out) begin
                    if_done_q  <= 1'b1;
                    err_q      <= 1'b1;
                    if_rdata_q <= '0;
                end
            end

            if (state == LS_WAIT) begin
                if (bus.mem_ready) begin
                    ls_done_q <= 1'b1;
                    // A store returns no data; ls_rdata keeps its old value.
                    if (!ls_we_q) ls_rdata_q <= bus.mem_rdata;
                end else if (timed_out) begin
                    ls_done_q  <= 1'b1;
                    err_q      <= 1'b1;
                    ls_rdata_q <= '0;
                end
            end
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_d;
    assign bus.mem_wr    = mem_wr_d;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios with literal expectations,
// plus a transaction-level model compared against every output each cycle.
module tb_cpu_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int T_OUT = 4;

    logic clk = 1'b0;
    logic reset;

    cpu_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cpu_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (T_OUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
    endtask

    // ------------------------------------------------------------------
    // Transaction model: who owns the bus and how many edges since grant.
    // ------------------------------------------------------------------
    typedef enum int {M_NONE, M_IF, M_LS} owner_t;

    owner_t      m_owner     = M_NONE;
    int          m_age       = 0;      // edges since the grant edge
    logic        m_last_ls   = 1'b0;   // last grant went to LS
    logic        m_we        = 1'b0;
    logic [31:0] m_addr      = '0;
    logic [31:0] m_wdata     = '0;
    logic [31:0] m_if_rdata  = '0;
    logic [31:0] m_ls_rdata  = '0;
    logic        m_if_done   = 1'b0;
    logic        m_ls_done   = 1'b0;
    logic        m_err       = 1'b0;
    logic        model_valid = 1'b0;

    task automatic model_step();
        logic   prev_if_done;
        logic   prev_ls_done;
        logic   want_if;
        logic   want_ls;
        owner_t pick;
        prev_if_done = m_if_done;
        prev_ls_done = m_ls_done;
        if (reset) begin
            model_valid = 1'b1;
            m_owner     = M_NONE;
            m_age       = 0;
            m_last_ls   = 1'b0;
            m_we        = 1'b0;
            m_addr      = '0;
            m_wdata     = '0;
            m_if_rdata  = '0;
            m_ls_rdata  = '0;
            m_if_done   = 1'b0;
            m_ls_done   = 1'b0;
            m_err       = 1'b0;
        end else begin
            m_if_done = 1'b0;
            m_ls_done = 1'b0;
            m_err     = 1'b0;
            if (m_owner == M_NONE) begin
                want_if = bus.if_req && !prev_if_done;
                want_ls = bus.ls_req && !prev_ls_done;
                pick = M_NONE;
                if (want_if && want_ls) pick = m_last_ls ? M_IF : M_LS;
                else if (want_if)       pick = M_IF;
                else if (want_ls)       pick = M_LS;
                if (pick != M_NONE) begin
                    m_owner   = pick;
                    m_age     = 0;
                    m_last_ls = (pick == M_LS);
                    if (pick == M_IF) begin
                        m_addr = bus.if_addr;
                    end else begin
                        m_addr  = bus.ls_addr;
                        m_wdata = bus.ls_wdata;
                        m_we    = bus.ls_we;
                    end
                end
            end else begin
                m_age++;
                // Edge 1 enters WAIT; ready is honoured from edge 2 on.
                if (m_age >= 2) begin
                    if (bus.mem_ready) begin
                        if (m_owner == M_IF) begin
                            m_if_done  = 1'b1;
                            m_if_rdata = bus.mem_rdata;
                        end else begin
                            m_ls_done = 1'b1;
                            if (!m_we) m_ls_rdata = bus.mem_rdata;
                        end
                        m_owner = M_NONE;
                    end else if (T_OUT != 0 && (m_age - 1) == T_OUT + 1) begin
                        m_err = 1'b1;
                        if (m_owner == M_IF) begin
                            m_if_done  = 1'b1;
                            m_if_rdata = '0;
                        end else begin
                            m_ls_done  = 1'b1;
                            m_ls_rdata = '0;
                        end
                        m_owner = M_NONE;
                    end
                end
            end
        end
    endtask

    task automatic compare_step();
        logic strobe;
        strobe = (m_owner != M_NONE) && (m_age == 0);
        check("mdl_mem_rd",    bus.mem_rd,    strobe && (m_owner == M_IF || !m_we));
        check("mdl_mem_wr",    bus.mem_wr,    strobe && (m_owner == M_LS) && m_we);
        check("mdl_mem_addr",  bus.mem_addr,  m_addr);
        check("mdl_mem_wdata", bus.mem_wdata, m_wdata);
        check("mdl_if_done",   bus.if_done,   m_if_done);
        check("mdl_ls_done",   bus.ls_done,   m_ls_done);
        check("mdl_err",       bus.err,       m_err);
        check("mdl_if_rdata",  bus.if_rdata,  m_if_rdata);
        check("mdl_ls_rdata",  bus.ls_rdata,  m_ls_rdata);
        check("done_overlap",  bus.if_done & bus.ls_done, 1'b0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_valid) compare_step();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    // Inputs change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"},  bus.mem_addr,  32'h0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_mem_rd"},    bus.mem_rd,    1'b0);
        check({tag, "_mem_wr"},    bus.mem_wr,    1'b0);
        check({tag, "_if_done"},   bus.if_done,   1'b0);
        check({tag, "_ls_done"},   bus.ls_done,   1'b0);
        check({tag, "_err"},       bus.err,       1'b0);
        check({tag, "_if_rdata"},  bus.if_rdata,  32'h0);
        check({tag, "_ls_rdata"},  bus.ls_rdata,  32'h0);
    endtask

    logic [31:0] cont_addr [4];
    logic [31:0] cont_data;

    initial begin
        cont_addr = '{32'h400, 32'h300, 32'h400, 32'h300};

        reset         = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;

        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // ---- Single fetch, ready at the first WAIT edge ----
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        tick();                                   // grant edge
        @(negedge clk);
        check("fetch_rd",   bus.mem_rd,   1'b1);
        check("fetch_addr", bus.mem_addr, 32'h100);
        tick();                                   // WAIT entry
        @(negedge clk);
        check("fetch_rd_once", bus.mem_rd, 1'b0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        tick();                                   // grant + 2: done
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("fetch_done",  bus.if_done,  1'b1);
        check("fetch_rdata", bus.if_rdata, 32'hDEADBEEF);
        check("fetch_err",   bus.err,      1'b0);
        tick();
        @(negedge clk);
        check("fetch_done_1cyc", bus.if_done, 1'b0);

        // ---- Store with 3 wait cycles ----
        bus.ls_req    = 1'b1;
        bus.ls_we     = 1'b1;
        bus.ls_addr   = 32'h2000;
        bus.ls_wdata  = 32'h12345678;
        bus.mem_rdata = 32'hAAAA5555;
        tick();                                   // grant edge
        @(negedge clk);
        check("store_wr",    bus.mem_wr,    1'b1);
        check("store_no_rd", bus.mem_rd,    1'b0);
        check("store_addr",  bus.mem_addr,  32'h2000);
        check("store_wdata", bus.mem_wdata, 32'h12345678);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 4) bus.mem_ready = 1'b1;
            @(negedge clk);
            check("store_hold_addr",  bus.mem_addr,  32'h2000);
            check("store_hold_wdata", bus.mem_wdata, 32'h12345678);
            check("store_hold_no_wr", bus.mem_wr,    1'b0);
            check("store_hold_no_rd", bus.mem_rd,    1'b0);
            check("store_early_done", bus.ls_done,   1'b0);
        end
        tick();                                   // grant + 5: done
        bus.mem_ready = 1'b0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        @(negedge clk);
        check("store_done",  bus.ls_done,  1'b1);
        check("store_err",   bus.err,      1'b0);
        check("store_rdata", bus.ls_rdata, 32'h0);

        // ---- Contention from reset: LS, IF, LS, IF ----
        reset       = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h400;
        tick();
        @(negedge clk);
        check_all_zero("reset2");
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();                               // grant edge
            @(negedge clk);
            check("cont_grant_addr", bus.mem_addr, cont_addr[k]);
            check("cont_grant_rd",   bus.mem_rd,   1'b1);
            cont_data     = 32'h1000_0000 + 32'(k);
            bus.mem_rdata = cont_data;
            tick();                               // WAIT entry
            bus.mem_ready = 1'b1;
            tick();                               // done edge
            bus.mem_ready = 1'b0;
            @(negedge clk);
            if (k % 2 == 0) begin
                check("cont_ls_done",  bus.ls_done,  1'b1);
                check("cont_if_quiet", bus.if_done,  1'b0);
                check("cont_ls_rdata", bus.ls_rdata, cont_data);
            end else begin
                check("cont_if_done",  bus.if_done,  1'b1);
                check("cont_ls_quiet", bus.ls_done,  1'b0);
                check("cont_if_rdata", bus.if_rdata, cont_data);
            end
            if (k == 3) begin
                bus.if_req = 1'b0;
                bus.ls_req = 1'b0;
            end
        end
        tick();

        // ---- Watchdog timeout on a load, then a late ready ----
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h500;
        tick();                                   // grant edge
        tick();                                   // WAIT entry
        for (int i = 1; i <= 4; i++) begin
            tick();
            @(negedge clk);
            check("to_early_done", bus.ls_done, 1'b0);
        end
        tick();                                   // WAIT entry + 5
        bus.ls_req = 1'b0;
        @(negedge clk);
        check("to_done",  bus.ls_done,  1'b1);
        check("to_err",   bus.err,      1'b1);
        check("to_rdata", bus.ls_rdata, 32'h0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5A5A5A5A;
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("late_ready_no_done", bus.ls_done, 1'b0);
        check("late_ready_no_err",  bus.err,     1'b0);
        tick();
        @(negedge clk);
        check("late_ready_idle", bus.ls_done | bus.mem_rd, 1'b0);

        // ---- Held fetch request across its done pulse ----
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h600;
        bus.mem_rdata = 32'hCAFEF00D;
        tick();                                   // grant edge
        tick();                                   // WAIT entry
        bus.mem_ready = 1'b1;
        tick();                                   // done edge
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("held_done",  bus.if_done,  1'b1);
        check("held_rdata", bus.if_rdata, 32'hCAFEF00D);
        tick();
        @(negedge clk);
        check("held_no_regrant", bus.mem_rd, 1'b0);
        tick();
        @(negedge clk);
        check("held_regrant",      bus.mem_rd,   1'b1);
        check("held_regrant_addr", bus.mem_addr, 32'h600);
        tick();                                   // WAIT entry
        bus.mem_ready = 1'b1;
        tick();                                   // done edge
        bus.mem_ready = 1'b0;
        bus.if_req    = 1'b0;
        @(negedge clk);
        check("held_done2", bus.if_done, 1'b1);
        tick();

        // ---- Reset during IF_WAIT discards the transfer ----
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h700;
        bus.mem_rdata = 32'h77777777;
        tick();                                   // grant edge
        tick();                                   // WAIT entry
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.if_req    = 1'b0;
        @(negedge clk);
        check_all_zero("rst_wait");
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("rst_no_done",   bus.if_done, 1'b0);
            check("rst_no_strobe", bus.mem_rd,  1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
